// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive/transmit pair.
//   - default frame geometry (data bits, oversampling ratio, centre tick)
//   - 8N1 frame length used by both uart_rx and uart_tx
//   - receiver state encoding
//   - majority-of-three helper used by the bit voter
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_TICK   = 8;

  // start + data + stop
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for an asynchronous serial line plus falling-edge
// detect on the synchronized value. All flops reset to 1 (UART idle level)
// so reset release never produces a spurious edge on an idle line.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   async_in   in   raw line, asynchronous to clk
//   sync_out   out  synchronized line
//   fall_pulse out  one-clk pulse: synchronized line went 1 -> 0
// ---------------------------------------------------------------------------
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out   = sync_q;
  assign fall_pulse = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, 16x oversampled. Each bit is decided by a majority vote
// of three samples around the bit centre. One rx_valid pulse per good frame,
// one frame_err pulse per frame whose stop bit votes low.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   en             in   receiver enable; low forces IDLE and clears counters
//   rx_line        in   serial input, idle high, asynchronous to clk
//   baud_tick_16x  in   one-clk strobe at 16x the bit rate
//   data_out       out  last correctly framed byte
//   rx_valid       out  one-clk pulse: data_out updated
//   rx_busy        out  high while a frame is in progress
//   frame_err      out  one-clk pulse: stop bit sampled low
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | validating the start bit; a high vote is a glitch -> IDLE
// DATA  | shifting in DATA_BITS bits, LSB first
// STOP  | voting the stop bit; leaves at the vote tick, not the bit end
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int MID_TICK   = UART_MID_TICK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx_line,
  input  logic                 baud_tick_16x,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] T_SAMP_A = TICK_W'(MID_TICK - 1);
  localparam logic [TICK_W-1:0] T_SAMP_B = TICK_W'(MID_TICK);
  localparam logic [TICK_W-1:0] T_VOTE   = TICK_W'(MID_TICK + 1);
  localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_fall;
  logic [1:0]           state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic                 vote_tick;
  logic                 end_tick;

  rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (rx_line),
    .sync_out   (rx_s),
    .fall_pulse (rx_fall)
  );

  // Third sample is the live synced value on the vote tick itself.
  assign vote      = majority3(samp_a, samp_b, rx_s);
  assign vote_tick = baud_tick_16x && (tick_cnt == T_VOTE);
  assign end_tick  = baud_tick_16x && (tick_cnt == T_LAST);
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state != IDLE && baud_tick_16x) begin
      if (tick_cnt == T_SAMP_A) samp_a <= rx_s;
      if (tick_cnt == T_SAMP_B) samp_b <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (state != IDLE && baud_tick_16x) tick_cnt <= tick_cnt + 1'b1;
        case (state)
          IDLE: begin
            if (rx_fall) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (vote_tick && vote) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (end_tick) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (vote_tick) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            if (end_tick) begin
              if (bit_cnt == BIT_LAST) state <= STOP;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            // Leave at the vote so a start edge right after the stop
            // bit centre is not missed.
            if (vote_tick) begin
              if (vote) begin
                data_out <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state    <= IDLE;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The bench serializes 8N1 frames onto rx_line
// at a 32-clk baud_tick_16x rate. Each frame it expects to be received is
// queued; a monitor pops and compares on every rx_valid / frame_err pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rx_line;
  logic       baud_tick_16x = 1'b0;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  logic       busy_seen = 1'b0;
  int         div_cnt   = 0;

  uart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .rx_line       (rx_line),
    .baud_tick_16x (baud_tick_16x),
    .data_out      (data_out),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == 31) begin
      div_cnt       <= 0;
      baud_tick_16x <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + 1;
      baud_tick_16x <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at a negedge, n baud ticks later.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_tick_16x !== 1'b1);
    end
    @(negedge clk);
  endtask

  // cut_kind: 0 none, 1 drop en mid data bit cut_bit, 2 reset mid data bit cut_bit
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int cut_bit, input int cut_kind);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop_b, d, 1'b0};
    if (cut_kind == 0) begin
      e.err  = ~stop_b;
      e.data = d;
      sb.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      wait_ticks(8);
      if (i == 1) check("busy_mid", 32'(rx_busy), 32'd1);
      if (cut_kind == 1 && i == cut_bit + 1) begin
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(rx_busy), 32'd0);
      end
      if (cut_kind == 2 && i == cut_bit + 1) begin
        rst_n = 1'b0;
        last_good = 8'h00;
        #1;
        check("rst_data",  32'(data_out),  32'd0);
        check("rst_valid", 32'(rx_valid),  32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_busy",  32'(rx_busy),   32'd0);
      end
      wait_ticks(8);
    end
    rx_line = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rx_busy === 1'b1) busy_seen = 1'b1;
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
          if (rx_valid === 1'b1) valid_cnt++;
          if (frame_err === 1'b1) err_cnt++;
          check("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
          check("sb_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pulse_kind", 32'(frame_err), 32'(e.err));
            if (e.err) begin
              check("data_hold", 32'(data_out), 32'(last_good));
            end else begin
              check("data", 32'(data_out), 32'(e.data));
              last_good = e.data;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data",  32'(data_out),  32'd0);
    check("reset_valid", 32'(rx_valid),  32'd0);
    check("reset_ferr",  32'(frame_err), 32'd0);
    check("reset_busy",  32'(rx_busy),   32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // single frame
    send_frame(8'hA5, 1'b1, -1, 0);
    wait_ticks(16);
    check("single_valid_cnt", 32'(valid_cnt), 32'd1);
    check("single_err_cnt",   32'(err_cnt),   32'd0);
    check("single_busy",      32'(rx_busy),   32'd0);
    check("single_data",      32'(data_out),  32'hA5);

    // back-to-back
    send_frame(8'hA5, 1'b1, -1, 0);
    send_frame(8'hAA, 1'b1, -1, 0);
    wait_ticks(16);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
    check("b2b_data",      32'(data_out),  32'hAA);

    // start-bit glitch
    busy_seen = 1'b0;
    rx_line = 1'b0;
    wait_ticks(4);
    rx_line = 1'b1;
    wait_ticks(16);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy",      32'(rx_busy),   32'd0);
    check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
    check("glitch_err_cnt",   32'(err_cnt),   32'd0);
    check("glitch_data",      32'(data_out),  32'hAA);

    // framing error then recovery
    send_frame(8'h3C, 1'b0, -1, 0);
    wait_ticks(16);
    check("ferr_err_cnt",   32'(err_cnt),   32'd1);
    check("ferr_valid_cnt", 32'(valid_cnt), 32'd3);
    check("ferr_data",      32'(data_out),  32'hAA);
    send_frame(8'h5A, 1'b1, -1, 0);
    wait_ticks(16);
    check("recover_data", 32'(data_out), 32'h5A);

    // enable abort at data bit 3
    send_frame(8'hFF, 1'b1, 3, 1);
    wait_ticks(16);
    check("abort_valid_cnt", 32'(valid_cnt), 32'd4);
    check("abort_err_cnt",   32'(err_cnt),   32'd1);
    check("abort_data",      32'(data_out),  32'h5A);
    en = 1'b1;
    wait_ticks(4);
    send_frame(8'h81, 1'b1, -1, 0);
    wait_ticks(16);
    check("reen_data", 32'(data_out), 32'h81);

    // reset mid-frame, held until the line is idle again
    send_frame(8'hC3, 1'b1, 3, 2);
    wait_ticks(2);
    rst_n = 1'b1;
    wait_ticks(4);
    check("post_rst_busy", 32'(rx_busy), 32'd0);
    send_frame(8'hC3, 1'b1, -1, 0);
    wait_ticks(16);
    check("post_rst_data",  32'(data_out),  32'hC3);
    check("final_valid_cnt", 32'(valid_cnt), 32'd6);
    check("final_err_cnt",   32'(err_cnt),   32'd1);
    check("sb_empty",        32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
